// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 33 cycles accept-to-done (special divides finish at accept).
// No input queueing: start is only sampled in IDLE; busy stalls the pipeline while computing.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_f3;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] opnd;
   logic            neg_q;
   logic            neg_r;

   logic            a_signed, b_signed, a_neg, b_neg;
   logic            is_div_req, div_zero, div_ovf, special;
   logic [XLEN-1:0] mag_a, mag_b, special_res;

   assign a_signed   = ~(funct3[0] & (funct3[1] | funct3[2]));
   assign b_signed   = a_signed & (funct3 != 3'b010);
   assign a_neg      = a_signed & srcA[XLEN-1];
   assign b_neg      = b_signed & srcB[XLEN-1];
   assign mag_a      = a_neg ? -srcA : srcA;
   assign mag_b      = b_neg ? -srcB : srcB;
   assign is_div_req = funct3[2];
   assign div_zero   = is_div_req & (srcB == '0);
   assign div_ovf    = is_div_req & ~funct3[0] & (srcA == MIN_NEG) & (srcB == '1);
   assign special    = div_zero | div_ovf;

   // REM* of a zero divisor returns the dividend; overflow REM returns 0.
   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = funct3[1] ? srcA : '1;
      else if (div_ovf)
         special_res = funct3[1] ? '0 : MIN_NEG;
   end

   // Multiply step: add multiplicand into the high half when the current multiplier bit is set.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   // Divide step: quotient bits shift in at acc[0] while dividend bits leave from the top.
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_diff;
   assign div_shift = {rem, acc[XLEN-1]};
   assign div_ge    = div_shift[XLEN] | (div_shift[XLEN-1:0] >= opnd);
   assign div_diff  = div_shift[XLEN-1:0] - opnd;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix  = neg_r ? -rem : rem;
      fix_res  = '0;
      if (op_f3[2])
         fix_res = op_f3[1] ? rem_fix : quo_fix;
      else if (op_f3[1:0] == 2'b00)
         fix_res = prod_fix[XLEN-1:0];
      else
         fix_res = prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         op_f3  <= '0;
         acc    <= '0;
         rem    <= '0;
         opnd   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (kill) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_f3 <= funct3;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  cnt   <= '0;
                  rem   <= '0;
                  opnd  <= is_div_req ? mag_b : mag_a;
                  acc   <= {{XLEN{1'b0}}, (is_div_req ? mag_a : mag_b)};
                  if (special) begin
                     result <= special_res;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (op_f3[2]) begin
                  acc[XLEN-1:0] <= {acc[XLEN-2:0], div_ge};
                  rem           <= div_ge ? div_diff : div_shift[XLEN-1:0];
               end else begin
                  acc <= mul_next;
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN-1))
                  state <= FIX;
            end
            FIX: begin
               result <= fix_res;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, random ops against an arithmetic model,
// kill, asynchronous reset and back-to-back issue.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        kill;
   logic [2:0]  funct3;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int vectors = 0;
   int miscompares = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .kill   (kill),
      .funct3 (funct3),
      .srcA   (srcA),
      .srcB   (srcB),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Reference result from plain 64-bit arithmetic; SV division truncates toward zero like RISC-V.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0] up;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      case (f)
         3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            sp = sa / sb; return sp[31:0];
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            sp = sa % sb; return sp[31:0];
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic spc;
      spc = f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      return spc ? 0 : 33;
   endfunction

   // Issue one op from an idle DUT (called #1 after a rising edge); returns timing and result observations.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc, output logic [31:0] res,
                        output logic [31:0] res_after, output logic done_after);
      funct3 = f; srcA = a; srcB = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      srcA = $urandom; srcB = $urandom; funct3 = 3'($urandom_range(0, 7));
      lat = -1; busy_cyc = 0; res = 'x;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) begin lat = k; res = result; break; end
         if (busy) busy_cyc++;
      end
      @(negedge clk);
      res_after = result;
      done_after = done;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; srcA = '0; srcB = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
      vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 00000000", result); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [2:0]  tf[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] ta[12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] tb[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] te[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
      int tl[12] = '{33, 33, 33, 33, 33, 33, 33, 33, 0, 0, 0, 0};
      int lat, bc; logic [31:0] res, ra; logic da;
      for (int i = 0; i < 12; i++) begin
         do_op(tf[i], ta[i], tb[i], lat, bc, res, ra, da);
         vectors++; if (res !== te[i]) begin miscompares++; $display("FAIL dir%0d_result: got %h expected %h", i, res, te[i]); end
         vectors++; if (lat != tl[i]) begin miscompares++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, tl[i]); end
         vectors++; if (bc != tl[i]) begin miscompares++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, tl[i]); end
         vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, da); end
         vectors++; if (ra !== te[i]) begin miscompares++; $display("FAIL dir%0d_result_hold: got %h expected %h", i, ra, te[i]); end
      end
   endtask

   task automatic test_random();
      int lat, bc, mode; logic [31:0] res, ra, a, b, exp; logic [2:0] f; logic da;
      for (int i = 0; i < 80; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom; b = $urandom;
         mode = $urandom_range(0, 7);
         if (mode == 0) b = 32'd0;
         else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (mode == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
         else if (mode == 3) b = -($urandom_range(1, 20));
         exp = model(f, a, b);
         do_op(f, a, b, lat, bc, res, ra, da);
         vectors++; if (res !== exp) begin miscompares++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp); end
         vectors++; if (lat != model_lat(f, a, b)) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, model_lat(f, a, b)); end
         vectors++; if (bc != model_lat(f, a, b)) begin miscompares++; $display("FAIL rnd%0d_busy_cycles: got %0d expected %0d", i, bc, model_lat(f, a, b)); end
      end
   endtask

   task automatic test_kill();
      int lat, bc, ndone; logic [31:0] res, ra; logic da;
      do_op(3'd0, 32'd6, 32'd7, lat, bc, res, ra, da);
      vectors++; if (res !== 32'd42) begin miscompares++; $display("FAIL kill_pre_result: got %h expected 0000002a", res); end
      funct3 = 3'd0; srcA = 32'h1111; srcB = 32'h2222; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL kill_busy: got %b expected 0", busy); end
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      vectors++; if (ndone != 0) begin miscompares++; $display("FAIL kill_no_done: got %0d expected 0", ndone); end
      vectors++; if (result !== 32'd42) begin miscompares++; $display("FAIL kill_result_kept: got %h expected 0000002a", result); end
      @(posedge clk); #1;
      do_op(3'd0, 32'd3, 32'd5, lat, bc, res, ra, da);
      vectors++; if (res !== 32'd15) begin miscompares++; $display("FAIL kill_post_mul: got %h expected 0000000f", res); end
      vectors++; if (lat != 33) begin miscompares++; $display("FAIL kill_post_latency: got %0d expected 33", lat); end
   endtask

   task automatic test_back_to_back();
      int ndone, k1, k2; logic [31:0] r1, r2;
      funct3 = 3'd0; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      funct3 = 3'd5; srcA = 32'd99; srcB = 32'd11;
      ndone = 0; k1 = -1; k2 = -1; r1 = 'x; r2 = 'x;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) begin k1 = k; r1 = result; end
            else begin k2 = k; r2 = result; break; end
         end
      end
      start = 1'b0;
      vectors++; if (k1 != 33) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 33", k1); end
      vectors++; if (r1 !== 32'd3000) begin miscompares++; $display("FAIL b2b_first_result: got %h expected 00000bb8", r1); end
      vectors++; if (k2 - k1 != 35) begin miscompares++; $display("FAIL b2b_gap: got %0d expected 35", k2 - k1); end
      vectors++; if (r2 !== 32'd9) begin miscompares++; $display("FAIL b2b_second_result: got %h expected 00000009", r2); end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      int lat, bc; logic [31:0] res, ra; logic da;
      funct3 = 3'd3; srcA = 32'h12345; srcB = 32'h777; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL arst_busy_before: got %b expected 1", busy); end
      #1 reset = 1'b1;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL arst_done: got %b expected 0", done); end
      vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL arst_result: got %h expected 00000000", result); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat, bc, res, ra, da);
      vectors++; if (res !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL arst_post_div: got %h expected fffffffd", res); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_kill();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
